// File: rtl/bus_transfer_ctrl.sv
// Sequences moves, writes and reads between dual-bus registers over BusA/BusB.
// Fixed 4-cycle transfer (DRIVE, LATCH, TURN, IDLE); new requests are only taken in IDLE.
module bus_transfer_ctrl #(
    parameter int NREG = 8,
    parameter int W    = 32
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            req_valid_i,
    output logic            req_ready_o,
    input  logic [1:0]      req_op_i,
    input  logic [2:0]      req_src_i,
    input  logic [2:0]      req_dst_i,
    input  logic            req_bus_i,
    input  logic [W-1:0]    req_data_i,
    inout  wire  [W-1:0]    bus_a_io,
    inout  wire  [W-1:0]    bus_b_io,
    output logic [NREG-1:0] store_o,
    output logic [NREG-1:0] store2_o,
    output logic [NREG-1:0] load_o,
    output logic [NREG-1:0] load2_o,
    output logic [W-1:0]    rd_data_o,
    output logic            rd_valid_o,
    output logic            busy_o,
    output logic            error_o
);

    typedef enum logic [1:0] {IDLE, DRIVE, LATCH, TURN} state_t;

    localparam logic [1:0] OP_MOVE  = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_READ  = 2'b10;
    localparam logic [1:0] OP_ILL   = 2'b11;

    state_t          state_q;
    logic [1:0]      op_q;
    logic [2:0]      src_q;
    logic [2:0]      dst_q;
    logic            bus_q;
    logic [W-1:0]    data_q;
    logic [NREG-1:0] store_q, store2_q, load_q, load2_q;
    logic            drv_a_q, drv_b_q;
    logic [W-1:0]    rd_data_q;
    logic            rd_valid_q, error_q;

    logic accept;
    logic reject;

    function automatic logic [NREG-1:0] onehot(input logic [2:0] idx);
        logic [NREG-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    assign req_ready_o = (state_q == IDLE) && !rst_i;
    assign accept      = req_valid_i && req_ready_o;
    assign reject      = (req_op_i == OP_ILL) ||
                         ((req_op_i == OP_MOVE) && (req_src_i == req_dst_i));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            op_q       <= OP_MOVE;
            src_q      <= '0;
            dst_q      <= '0;
            bus_q      <= 1'b0;
            data_q     <= '0;
            store_q    <= '0;
            store2_q   <= '0;
            load_q     <= '0;
            load2_q    <= '0;
            drv_a_q    <= 1'b0;
            drv_b_q    <= 1'b0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            rd_valid_q <= 1'b0;
            error_q    <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept && reject) begin
                        error_q <= 1'b1;
                    end else if (accept) begin
                        state_q <= DRIVE;
                        op_q    <= req_op_i;
                        src_q   <= req_src_i;
                        dst_q   <= req_dst_i;
                        bus_q   <= req_bus_i;
                        data_q  <= req_data_i;
                        // Source driver comes up with DRIVE so the bus settles a cycle before capture.
                        if (req_op_i == OP_WRITE) begin
                            drv_a_q <= !req_bus_i;
                            drv_b_q <= req_bus_i;
                        end else if (req_bus_i) begin
                            store2_q <= onehot(req_src_i);
                        end else begin
                            store_q  <= onehot(req_src_i);
                        end
                    end
                end
                DRIVE: begin
                    state_q <= LATCH;
                    if (op_q != OP_READ) begin
                        if (bus_q) load2_q <= onehot(dst_q);
                        else       load_q  <= onehot(dst_q);
                    end
                end
                LATCH: begin
                    state_q  <= TURN;
                    store_q  <= '0;
                    store2_q <= '0;
                    load_q   <= '0;
                    load2_q  <= '0;
                    drv_a_q  <= 1'b0;
                    drv_b_q  <= 1'b0;
                    if (op_q == OP_READ) begin
                        rd_data_q  <= bus_q ? bus_b_io : bus_a_io;
                        rd_valid_q <= 1'b1;
                    end
                end
                TURN: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus_a_io   = drv_a_q ? data_q : 'z;
    assign bus_b_io   = drv_b_q ? data_q : 'z;
    assign store_o    = store_q;
    assign store2_o   = store2_q;
    assign load_o     = load_q;
    assign load2_o    = load2_q;
    assign rd_data_o  = rd_data_q;
    assign rd_valid_o = rd_valid_q;
    assign busy_o     = (state_q != IDLE);
    assign error_o    = error_q;

endmodule

// File: tb/tb_bus_transfer_ctrl.sv
// Directed bench for bus_transfer_ctrl with a behavioural bank of dual-bus registers.
module tb_bus_transfer_ctrl;

    localparam int NREG = 8;
    localparam int W    = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic            req_valid;
    logic            req_ready;
    logic [1:0]      req_op;
    logic [2:0]      req_src;
    logic [2:0]      req_dst;
    logic            req_bus;
    logic [W-1:0]    req_data;
    wire  [W-1:0]    bus_a;
    wire  [W-1:0]    bus_b;
    logic [NREG-1:0] store, store2, load, load2;
    logic [W-1:0]    rd_data;
    logic            rd_valid, busy, error;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int viol   = 0;

    logic [W-1:0] regs [NREG];
    logic         seed;
    logic [W-1:0] a_val, b_val;
    logic         a_en, b_en;

    always #5 clk = ~clk;

    bus_transfer_ctrl #(.NREG(NREG), .W(W)) dut (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(req_valid), .req_ready_o(req_ready),
        .req_op_i(req_op), .req_src_i(req_src), .req_dst_i(req_dst),
        .req_bus_i(req_bus), .req_data_i(req_data),
        .bus_a_io(bus_a), .bus_b_io(bus_b),
        .store_o(store), .store2_o(store2), .load_o(load), .load2_o(load2),
        .rd_data_o(rd_data), .rd_valid_o(rd_valid), .busy_o(busy), .error_o(error)
    );

    // Register bank model: drives a bus while its Store is up, captures on Load.
    always_comb begin
        a_val = '0; a_en = 1'b0;
        b_val = '0; b_en = 1'b0;
        for (int i = 0; i < NREG; i++) begin
            if (store[i])  begin a_val = regs[i]; a_en = 1'b1; end
            if (store2[i]) begin b_val = regs[i]; b_en = 1'b1; end
        end
    end
    assign bus_a = a_en ? a_val : 'z;
    assign bus_b = b_en ? b_val : 'z;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        for (int i = 0; i < NREG; i++) begin
            if (seed)          regs[i] <= 32'hA000_0000 + i;
            else if (load[i])  regs[i] <= bus_a;
            else if (load2[i]) regs[i] <= bus_b;
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            if ($countones(store | store2) > 1) viol++;
            if ($countones(load | load2) > 1)   viol++;
            if ((|(store | load)) && (|(store2 | load2))) viol++;
            if ((|store2) && !$isunknown(bus_a) && bus_a != '0) viol++;
            if ((|store) && !$isunknown(bus_b) && bus_b != '0) viol++;
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic released(input logic [W-1:0] v);
        return $isunknown(v) || (v == '0);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [1:0] op, input logic [2:0] src, input logic [2:0] dst,
                         input logic bus, input logic [W-1:0] data);
        req_valid = 1'b1;
        req_op    = op;
        req_src   = src;
        req_dst   = dst;
        req_bus   = bus;
        req_data  = data;
        tick();
        req_valid = 1'b0;
    endtask

    logic [31:0] en_all;
    int          acc [3];
    int          n;

    initial begin
        rst = 1'b1; seed = 1'b1;
        req_valid = 1'b0; req_op = 2'b00; req_src = '0; req_dst = '0;
        req_bus = 1'b0; req_data = '0;
        tick(); tick();
        seed = 1'b0;
        chk("rst_ready", {63'd0, req_ready}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_enables", {32'd0, store, store2, load, load2}, 64'd0);
        chk("rst_rddata", {32'd0, rd_data}, 64'd0);
        chk("rst_pulses", {62'd0, rd_valid, error}, 64'd0);
        rst = 1'b0;
        #1;
        chk("ready_after_rst", {63'd0, req_ready}, 64'd1);

        // WRITE 0xDEADBEEF into reg3 over BusA
        issue(2'b01, 3'd0, 3'd3, 1'b0, 32'hDEAD_BEEF);
        chk("wr_drive_busa", {32'd0, bus_a}, 64'hDEAD_BEEF);
        chk("wr_drive_load", {56'd0, load}, 64'd0);
        chk("wr_drive_busy", {62'd0, busy, req_ready}, 64'd2);
        tick();
        chk("wr_latch_load", {48'd0, load, load2}, 64'h0800);
        tick();
        en_all = {store, store2, load, load2};
        chk("wr_turn_enables", {32'd0, en_all}, 64'd0);
        chk("wr_turn_busa_z", {63'd0, released(bus_a)}, 64'd1);
        tick();
        chk("wr_reg3", {32'd0, regs[3]}, 64'hDEAD_BEEF);
        chk("wr_ready", {63'd0, req_ready}, 64'd1);

        // MOVE reg3 -> reg5 over BusB
        issue(2'b00, 3'd3, 3'd5, 1'b1, 32'h0);
        chk("mv_drive", {32'd0, store, store2, load, load2}, 64'h0008_0000);
        tick();
        chk("mv_latch", {32'd0, store, store2, load, load2}, 64'h0008_0020);
        chk("mv_latch_busb", {32'd0, bus_b}, 64'hDEAD_BEEF);
        tick();
        chk("mv_turn", {32'd0, store, store2, load, load2}, 64'd0);
        tick();
        chk("mv_reg5", {32'd0, regs[5]}, 64'hDEAD_BEEF);

        // READ reg5 over BusA
        issue(2'b10, 3'd5, 3'd0, 1'b0, 32'h0);
        chk("rd_drive_store", {32'd0, store, store2, load, load2}, 64'h2000_0000);
        tick();
        chk("rd_latch_store", {32'd0, store, store2, load, load2}, 64'h2000_0000);
        chk("rd_latch_novalid", {63'd0, rd_valid}, 64'd0);
        tick();
        chk("rd_turn_valid", {63'd0, rd_valid}, 64'd1);
        chk("rd_turn_data", {32'd0, rd_data}, 64'hDEAD_BEEF);
        chk("rd_turn_ready", {63'd0, req_ready}, 64'd0);
        tick();
        chk("rd_idle", {62'd0, rd_valid, req_ready}, 64'd1);
        chk("rd_data_hold", {32'd0, rd_data}, 64'hDEAD_BEEF);

        // Rejections: MOVE src==dst, then illegal opcode
        issue(2'b00, 3'd2, 3'd2, 1'b0, 32'h0);
        chk("rej_mv_err", {62'd0, error, busy}, 64'd2);
        chk("rej_mv_en", {32'd0, store, store2, load, load2}, 64'd0);
        tick();
        chk("rej_mv_pulse", {63'd0, error}, 64'd0);
        issue(2'b11, 3'd1, 3'd4, 1'b1, 32'h5);
        chk("rej_ill_err", {62'd0, error, busy}, 64'd2);
        chk("rej_ill_en", {32'd0, store, store2, load, load2}, 64'd0);
        tick();
        chk("rej_ill_pulse", {62'd0, error, busy}, 64'd0);

        // Three WRITEs with ReqValid held high
        req_valid = 1'b1;
        req_op    = 2'b01;
        req_bus   = 1'b0;
        for (int k = 0; k < 3; k++) begin
            req_dst  = 3'(k);
            req_data = 32'h1111_1111 * (k + 1);
            n = 0;
            while (!req_ready && n < 10) begin
                tick();
                n++;
            end
            if (n >= 10) chk("b2b_wait", 64'd0, 64'd1);
            acc[k] = cyc;
            tick();
        end
        req_valid = 1'b0;
        tick(); tick(); tick();
        chk("b2b_gap01", 64'(acc[1] - acc[0]), 64'd4);
        chk("b2b_gap12", 64'(acc[2] - acc[1]), 64'd4);
        chk("b2b_reg0", {32'd0, regs[0]}, 64'h1111_1111);
        chk("b2b_reg1", {32'd0, regs[1]}, 64'h2222_2222);
        chk("b2b_reg2", {32'd0, regs[2]}, 64'h3333_3333);

        // Reset while a MOVE is in LATCH
        issue(2'b00, 3'd0, 3'd6, 1'b0, 32'h0);
        tick();
        chk("rl_in_latch", {48'd0, load, load2}, 64'h4000);
        rst = 1'b1;
        tick();
        chk("rl_enables", {32'd0, store, store2, load, load2}, 64'd0);
        chk("rl_busy", {62'd0, busy, rd_valid}, 64'd0);
        chk("rl_bus_z", {62'd0, released(bus_a), released(bus_b)}, 64'd3);
        rst = 1'b0;
        #1;
        chk("rl_ready", {63'd0, req_ready}, 64'd1);

        // Reset before the Load edge leaves the destination untouched
        issue(2'b00, 3'd1, 3'd7, 1'b1, 32'h0);
        rst = 1'b1;
        tick();
        chk("rd_abort_en", {32'd0, store, store2, load, load2}, 64'd0);
        rst = 1'b0;
        tick(); tick();
        chk("rd_abort_reg7", {32'd0, regs[7]}, 64'hA000_0007);

        chk("invariants", 64'(viol), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule

// File: doc/bus_transfer_ctrl.md
BUS_TRANSFER_CTRL -- requirements
Module: bus_transfer_ctrl

Interface
REQ-001 Parameter NREG, default 8, number of dual-bus registers controlled (3-bit index).
REQ-002 Parameter W, default 32, data bus width.
REQ-003 Clk  input  1  sole clock; all state updates on rising edge.
REQ-004 Reset  input  1  synchronous, active-high reset.
REQ-005 ReqValid  input  1  transfer request present.
REQ-006 ReqReady  output  1  controller accepts request this cycle.
REQ-007 ReqOp  input  2  operation: 00 MOVE reg->reg, 01 WRITE ReqData->reg, 10 READ reg->RdData, 11 illegal.
REQ-008 ReqSrc  input  3  source register index (MOVE, READ).
REQ-009 ReqDst  input  3  destination register index (MOVE, WRITE).
REQ-010 ReqBus  input  1  bus select: 0 = BusA (register IN/Load/Store side), 1 = BusB (IN2/Load2/Store2 side).
REQ-011 ReqData  input  W  write data for WRITE.
REQ-012 BusA  inout  W  shared bus A; driven by controller only during WRITE drive phases, else high-Z.
REQ-013 BusB  inout  W  shared bus B; same rule as BusA.
REQ-014 Store  output  NREG  per-register output enable onto BusA.
REQ-015 Store2  output  NREG  per-register output enable onto BusB.
REQ-016 Load  output  NREG  per-register capture from BusA.
REQ-017 Load2  output  NREG  per-register capture from BusB.
REQ-018 RdData  output  W  data captured by READ.
REQ-019 RdValid  output  1  one-cycle pulse, RdData valid.
REQ-020 Busy  output  1  high whenever state is not IDLE.
REQ-021 Error  output  1  one-cycle pulse on rejected request.

Function
REQ-022 FSM states IDLE, DRIVE, LATCH, TURN; all outputs registered, no combinational path input->Store/Load.
REQ-023 ReqReady SHALL be 1 only in IDLE and not in reset; accept = ReqValid & ReqReady; Op/Src/Dst/Bus/Data latched at accept.
REQ-024 Rejection: ReqOp=11, or MOVE with ReqSrc==ReqDst -> Error=1 next cycle, state stays IDLE, no enable asserted.
REQ-025 IDLE->DRIVE on valid accept; DRIVE->LATCH->TURN->IDLE unconditionally, one cycle each; one transfer per 4 cycles max.
REQ-026 DRIVE: source driver on selected bus enabled (Store/Store2[src] for MOVE/READ; controller drives latched data for WRITE); no Load asserted.
REQ-027 LATCH: source driver held; Load/Load2[dst] = 1 for MOVE/WRITE; READ samples selected bus into RdData at the edge ending LATCH.
REQ-028 TURN: all Store/Store2/Load/Load2 = 0, controller buses high-Z; READ pulses RdValid=1 with RdData stable.
REQ-029 At most one driver per bus in any cycle; the unselected bus is never driven and its enables stay 0.
REQ-030 At most one bit set across Store|Store2 and across Load|Load2 at any time (one-hot or zero).
REQ-031 RdData holds last READ value until next READ completes.
REQ-032 ReqValid in non-IDLE states is ignored (not queued); requester must hold until ReqReady.

Reset
REQ-033 Reset=1 at an edge -> state IDLE, all Store/Store2/Load/Load2=0, RdValid=0, Error=0, Busy=0, RdData=0, BusA/BusB high-Z after that edge.
REQ-034 Reset mid-transfer aborts it; any Load not yet sampled is lost, no RdValid pulse; ReqReady=1 from first cycle with Reset=0.

Verification
REQ-035 WRITE dst=3 bus=0 data=0xDEADBEEF -> DRIVE: BusA=0xDEADBEEF; LATCH: Load=0x08; TURN: all enables 0, BusA=Z; reg3=0xDEADBEEF.
REQ-036 MOVE src=3 dst=5 bus=1 -> DRIVE: Store2=0x08; LATCH: Store2=0x08, Load2=0x20; reg5=0xDEADBEEF; Store/Load stay 0.
REQ-037 READ src=5 bus=0 -> LATCH: Store=0x20; TURN: RdValid=1, RdData=0xDEADBEEF; ReqReady returns 1 after TURN.
REQ-038 MOVE src=2 dst=2, then ReqOp=11 -> Error pulses once each, Busy stays 0, no enable asserted.
REQ-039 Back-to-back ReqValid held high with 3 WRITEs -> accepts exactly every 4 cycles, bus never multiply driven (no X on bus).
REQ-040 Reset asserted during LATCH of a MOVE -> next cycle all enables 0, Busy=0, bus Z; destination unchanged if reset edge precedes Load edge.
